// File: rtl/pal_cfg_loader.sv
// rtl/pal_cfg_loader.sv - PAL configuration chain loader (byte stream to serial chain)
//
// Accepts configuration bytes over a valid/ready handshake and shifts them
// LSB-first onto the fabric configuration chain. Exactly CFG_BITS bits are
// shifted per session; the session then completes (done_o) or is aborted (err_o).
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   start_i      begin a session (ignored while busy_o)
//   abort_i      terminate the active session
//   din_i        configuration byte, bit 0 shifted first
//   din_valid_i  din_i holds a valid byte
//   din_ready_o  loader accepts din_i this cycle (decoded from state)
//   cfg_data_o   serial configuration bit (registered)
//   cfg_en_o     fabric shifts cfg_data_o at the next rising edge (registered)
//   busy_o       session active (WAIT or SHIFT)
//   done_o       last session shifted all CFG_BITS bits (sticky)
//   err_o        last session was aborted (sticky)
module pal_cfg_loader #(
  parameter int CFG_BITS = 288
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic [7:0] din_i,
  input  logic       din_valid_i,
  output logic       din_ready_o,
  output logic       cfg_data_o,
  output logic       cfg_en_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);

  localparam int TW = $clog2(CFG_BITS + 1);
  // Value of tot_cnt while the final bit of the session is on the chain.
  localparam logic [TW-1:0] LAST_IDX = TW'(CFG_BITS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_SHIFT, ST_FIN} state_e;

  state_e        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [TW-1:0] tot_cnt_q, tot_cnt_d;
  logic [7:0]    sreg_q, sreg_d;
  logic          cfg_data_q, cfg_data_d;
  logic          cfg_en_q, cfg_en_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          more_bits;
  logic          din_ready;
  logic          handshake;
  logic [2:0]    nxt_bit;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      tot_cnt_q  <= '0;
      sreg_q     <= '0;
      cfg_data_q <= 1'b0;
      cfg_en_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      tot_cnt_q  <= tot_cnt_d;
      sreg_q     <= sreg_d;
      cfg_data_q <= cfg_data_d;
      cfg_en_q   <= cfg_en_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    // The bit now on the chain is not the last one of the session.
    more_bits  = (tot_cnt_q < LAST_IDX);
    // During bit 7 the next byte may be taken so shifting continues without a bubble.
    din_ready  = (state_q == ST_WAIT) ||
                 ((state_q == ST_SHIFT) && (bit_cnt_q == 3'd7) && more_bits);
    handshake  = din_valid_i && din_ready;
    nxt_bit    = bit_cnt_q + 3'd1;

    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    tot_cnt_d  = tot_cnt_q;
    sreg_d     = sreg_q;
    cfg_data_d = cfg_data_q;
    cfg_en_d   = 1'b0;
    done_d     = done_q;
    err_d      = err_q;

    case (state_q)
      ST_IDLE, ST_FIN: begin
        if (start_i) begin
          state_d   = ST_WAIT;
          tot_cnt_d = '0;
          done_d    = 1'b0;
          err_d     = 1'b0;
        end
      end
      ST_WAIT: begin
        if (abort_i) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else if (handshake) begin
          state_d    = ST_SHIFT;
          sreg_d     = din_i;
          bit_cnt_d  = 3'd0;
          cfg_data_d = din_i[0];
          cfg_en_d   = 1'b1;
        end
      end
      ST_SHIFT: begin
        // cfg_en is high throughout SHIFT, so the fabric captures a bit at every edge.
        tot_cnt_d = tot_cnt_q + TW'(1);
        if (abort_i) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else if (!more_bits) begin
          // Remaining upper bits of a partial final byte are simply dropped.
          state_d = ST_FIN;
          done_d  = 1'b1;
        end else if (bit_cnt_q != 3'd7) begin
          bit_cnt_d  = nxt_bit;
          cfg_data_d = sreg_q[nxt_bit];
          cfg_en_d   = 1'b1;
        end else if (handshake) begin
          sreg_d     = din_i;
          bit_cnt_d  = 3'd0;
          cfg_data_d = din_i[0];
          cfg_en_d   = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign din_ready_o = din_ready;
  assign cfg_data_o  = cfg_data_q;
  assign cfg_en_o    = cfg_en_q;
  assign busy_o      = (state_q == ST_WAIT) || (state_q == ST_SHIFT);
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_pal_cfg_loader.sv
// tb/tb_pal_cfg_loader.sv - self-checking bench for pal_cfg_loader
module tb_pal_cfg_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0, abort = 1'b0, din_valid = 1'b0;
  logic [7:0] din = 8'h00;
  logic       din_ready, cfg_data, cfg_en, busy, done, err;

  logic       s_start = 1'b0, s_abort = 1'b0, s_valid = 1'b0;
  logic [7:0] s_din = 8'h00;
  logic       s_ready, s_data, s_en, s_busy, s_done, s_err;

  always #5 clk = ~clk;

  pal_cfg_loader #(.CFG_BITS(288)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
    .din_i(din), .din_valid_i(din_valid), .din_ready_o(din_ready),
    .cfg_data_o(cfg_data), .cfg_en_o(cfg_en), .busy_o(busy),
    .done_o(done), .err_o(err)
  );

  pal_cfg_loader #(.CFG_BITS(20)) u_dut20 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(s_start), .abort_i(s_abort),
    .din_i(s_din), .din_valid_i(s_valid), .din_ready_o(s_ready),
    .cfg_data_o(s_data), .cfg_en_o(s_en), .busy_o(s_busy),
    .done_o(s_done), .err_o(s_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Fabric model for the 288-bit instance: captures cfg_data on every cycle with cfg_en.
  bit cap[$];
  int en_cnt;
  int gaps;
  bit seen_en;

  task automatic step();
    @(negedge clk);
    if (cfg_en) begin
      cap.push_back(cfg_data);
      en_cnt++;
      seen_en = 1'b1;
    end else if (busy && seen_en) begin
      gaps++;
    end
  endtask

  typedef struct {
    string name;
    int    stall_idx;
    int    stall_len;
    int    abort_at;
    int    start_at;
    int    exp_en;
    int    exp_gaps;
    int    exp_bytes;
    int    exp_done;
    int    exp_err;
  } scen_t;

  scen_t tbl[5];

  initial begin
    int idx, stall_left, mism, k, n_en;
    bit aborted, pulsed, timed_out;
    bit q20[$];
    logic [7:0] b20 [3];
    logic [7:0] bv;

    tbl[0] = '{"full",       -1, 0,   0,  0, 288, 0, 36, 1, 0};
    tbl[1] = '{"stall",       4, 5,   0,  0, 288, 5, 36, 1, 0};
    tbl[2] = '{"abort",      -1, 0, 100,  0, 104, 0, 13, 0, 1};
    tbl[3] = '{"reload",     -1, 0,   0,  0, 288, 0, 36, 1, 0};
    tbl[4] = '{"start_busy", -1, 0,   0, 50, 288, 0, 36, 1, 0};
    b20[0] = 8'hA5; b20[1] = 8'h3C; b20[2] = 8'hFF;

    // Asynchronous reset, checked between clock edges.
    #2 rst_n = 1'b0;
    #1;
    chk("reset_outs", int'({din_ready, cfg_data, cfg_en, busy, done, err}), 0);
    chk("reset_outs20", int'({s_ready, s_data, s_en, s_busy, s_done, s_err}), 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_outs", int'({din_ready, cfg_data, cfg_en, busy, done, err}), 0);

    // Partial final byte on a 20-bit chain.
    s_start = 1'b1; @(negedge clk); s_start = 1'b0;
    chk("c20_start_ready", int'({s_busy, s_ready}), 3);
    k = 0; n_en = 0; timed_out = 1'b1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (s_done) begin timed_out = 1'b0; break; end
      s_valid = 1'b1;
      s_din = (k < 3) ? b20[k] : 8'h77;
      if (s_ready) k++;
      @(negedge clk);
      if (s_en) begin q20.push_back(s_data); n_en++; end
    end
    chk("c20_timeout", int'(timed_out), 0);
    for (int c = 0; c < 8; c++) begin
      s_valid = 1'b1; s_din = 8'h77;
      if (s_ready) k++;
      @(negedge clk);
      if (s_en) n_en++;
    end
    s_valid = 1'b0;
    chk("c20_en_cycles", n_en, 20);
    chk("c20_bytes_taken", k, 3);
    mism = 0;
    for (int i = 0; i < 20; i++) begin
      bv = b20[i / 8];
      if (q20.size() <= i || q20[i] != bv[i % 8]) mism++;
    end
    chk("c20_stream", mism, 0);
    if (q20.size() >= 20) chk("c20_last4", int'({q20[16], q20[17], q20[18], q20[19]}), 15);
    else chk("c20_last4_len", q20.size(), 20);
    chk("c20_done_busy", int'({s_done, s_busy, s_ready, s_err}), 8);

    // Table-driven sessions on the 288-bit chain.
    foreach (tbl[s]) begin
      cap.delete(); en_cnt = 0; gaps = 0; seen_en = 1'b0;
      step(); start = 1'b1; step(); start = 1'b0;
      chk({tbl[s].name, "_start"}, int'({busy, din_ready, done, err}), 12);
      idx = 0; stall_left = tbl[s].stall_len;
      aborted = 1'b0; pulsed = 1'b0; timed_out = 1'b1;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        din_valid = 1'b1; din = 8'(idx);
        if (idx == tbl[s].stall_idx && stall_left > 0 && din_ready) begin
          din_valid = 1'b0; stall_left--;
        end
        if (tbl[s].abort_at > 0 && en_cnt >= tbl[s].abort_at && din_ready && din_valid) begin
          abort = 1'b1; aborted = 1'b1;
        end else if (din_valid && din_ready) begin
          idx++;
        end
        if (tbl[s].start_at > 0 && en_cnt == tbl[s].start_at && !pulsed) begin
          start = 1'b1; pulsed = 1'b1;
        end
        step(); abort = 1'b0; start = 1'b0;
        if (aborted || done) begin timed_out = 1'b0; break; end
      end
      chk({tbl[s].name, "_timeout"}, int'(timed_out), 0);
      chk({tbl[s].name, "_flags"}, int'({done, err, busy, cfg_en, din_ready}),
          int'({tbl[s].exp_done[0], tbl[s].exp_err[0], 3'b000}));
      for (int c = 0; c < 6; c++) begin
        din_valid = 1'b1; din = 8'(idx);
        if (din_ready) idx++;
        step();
      end
      din_valid = 1'b0;
      chk({tbl[s].name, "_en_cycles"}, en_cnt, tbl[s].exp_en);
      chk({tbl[s].name, "_gaps"}, gaps, tbl[s].exp_gaps);
      chk({tbl[s].name, "_bytes_taken"}, idx, tbl[s].exp_bytes);
      mism = 0;
      for (int i = 0; i < tbl[s].exp_en; i++) begin
        bv = 8'(i / 8);
        if (cap.size() <= i || cap[i] != bv[i % 8]) mism++;
      end
      chk({tbl[s].name, "_stream"}, mism, 0);
      chk({tbl[s].name, "_sticky"}, int'({done, err}),
          int'({tbl[s].exp_done[0], tbl[s].exp_err[0]}));
    end

    // Reset in the middle of a shift: outputs clear at once, no flag survives.
    step(); start = 1'b1; step(); start = 1'b0;
    din_valid = 1'b1; din = 8'h5A;
    repeat (4) step();
    chk("mid_shift_active", int'({busy, cfg_en}), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_reset_outs", int'({din_ready, cfg_data, cfg_en, busy, done, err}), 0);
    @(negedge clk); rst_n = 1'b1; din_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_reset_outs", int'({din_ready, cfg_data, cfg_en, busy, done, err}), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
